register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   RISC-V integer register file, x0..x31, each N bits wide.
//   Sits between instruction decode and the ALU:
//     - two combinational read ports feed the ALU operands (rs1, rs2).
//     - one synchronous write port takes writeback (rd).
//   x0 is hardwired to zero.
//   Write-first bypass: a value written this cycle is visible on the read ports in the same cycle.
// PARAMETERS
//   N      64  data width of every register, in bits
//   ADDR   5   register index width; number of registers = 2**ADDR (32)
// PORTS
//   clk         in   1     clock; all state updates on the rising edge
//   reset       in   1     synchronous, active-high; clears x1..x31 at the rising edge
//   reg_write   in   1     write enable for the write port
//   rd          in   ADDR  write register index
//   write_data  in   N     data to write into rd
//   rs1         in   ADDR  read port 1 register index
//   rs2         in   ADDR  read port 2 register index
//   read_data1  out  N     contents of rs1 (combinational)
//   read_data2  out  N     contents of rs2 (combinational)
// BEHAVIOUR
//   Storage: 2**ADDR - 1 registers (x1..x31). x0 has no storage.
//   Reset:
//     - reset=1 at a rising edge sets x1..x31 to 0.
//     - reset has priority over reg_write in the same cycle; the write is dropped.
//     - While reset=1, read_data1 and read_data2 are forced to 0, with bypass disabled.
//   Write:
//     - When reg_write=1, reset=0 and rd!=0, x[rd] <= write_data at the rising edge.
//     - When rd==0 the write is silently discarded; no state changes.
//     - When reg_write=0, all registers hold their value.
//   Read (per port p in {1,2}, index rsp):
//     - rsp==0                               -> read_datap = 0, always, incl. bypass case.
//     - reset=1                              -> read_datap = 0.
//     - reg_write=1 and rd==rsp and rsp!=0   -> read_datap = write_data (bypass, same cycle).
//     - otherwise                            -> read_datap = x[rsp] (stored value).
//   Latency:
//     - Reads are 0-cycle combinational.
//     - A write reaches storage 1 edge later, but is visible immediately via bypass.
//   Simultaneous events:
//     - rs1==rs2: both ports return identical data, including bypassed data.
//     - rd equal to both rs1 and rs2: both ports are bypassed.
//     - Write and read of different registers: the read returns the old stored value of its own register.
//   Reset mid-operation: an asserted reset during a write sequence clears everything at that edge.
//     Registers written before the reset read 0 afterwards.
//   Width: write_data is stored unmodified; no sign or zero extension is done here.
//   No X on outputs after the first reset edge; behaviour before the first reset is undefined.
// TESTING
//   T1 reset: reset=1 for 1 edge -> rs1 = 1..31 sweep on both ports reads 0.
//      Reads are 0 while reset=1 even with reg_write=1, rd=5, write_data=FF.
//   T2 write/read:
//      - write x5=64'h0123_4567_89AB_CDEF and x31=64'hFFFF_FFFF_FFFF_FFFF.
//      - next cycle, rs1=5, rs2=31 -> exact values.
//      - x6 still 0.
//   T3 x0:
//      - reg_write=1, rd=0, write_data=64'hDEAD -> rs1=0 reads 0 the same cycle (no bypass).
//      - rs1=0 still reads 0 next cycle.
//      - no other register changes.
//   T4 bypass: x7 holds 64'h11.
//      - Drive reg_write=1, rd=7, write_data=64'h22, rs1=7, rs2=7.
//      - Before the edge, both ports read 64'h22.
//      - After the edge with reg_write=0, both still read 64'h22.
//   T5 hold/no-write:
//      - reg_write=0 with rd=9, write_data=64'hAA for 3 edges -> x9 unchanged (0).
//      - Writing x9 does not alter x8 or x10.
//   T6 reset mid-operation:
//      - write x3=64'h33, x4=64'h44.
//      - On the next edge, assert reset=1 with reg_write=1, rd=3, write_data=64'h99.
//      - Result: x3=0, x4=0, and 64'h99 is never stored.

Source files
------------

// File: rtl/register_file.sv
// RISC-V integer register file: x0 reads as zero, x1..x31 hold N-bit values.
// Two combinational read ports feed the ALU operands and one synchronous write
// port takes writeback. A write in flight is forwarded to the read ports in the
// same cycle (write-first bypass), so decode never sees a stale operand.
module register_file #(
   parameter int N    = 64,
   parameter int ADDR = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            reg_write,
   input  logic [ADDR-1:0] rd,
   input  logic [N-1:0]    write_data,
   input  logic [ADDR-1:0] rs1,
   input  logic [ADDR-1:0] rs2,
   output logic [N-1:0]    read_data1,
   output logic [N-1:0]    read_data2
);

   localparam int NREG = 2 ** ADDR;

   // x0 has no storage; indices start at 1
   logic [N-1:0] regs [1:NREG-1];

   // A write is live only when enabled, not in reset and not aimed at x0
   logic write_live;
   assign write_live = reg_write && !reset && (rd != '0);

   // Storage update: reset clears x1..x31 and wins over a same-cycle write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (write_live) begin
         regs[rd] <= write_data;
      end
   end

   // Read port 1: zero for x0 or reset, else forwarded write data, else stored value
   always_comb begin
      read_data1 = '0;
      if (rs1 != '0 && !reset) begin
         if (write_live && rd == rs1) begin
            read_data1 = write_data;
         end else begin
            read_data1 = regs[rs1];
         end
      end
   end

   // Read port 2: same selection as port 1, driven from rs2
   always_comb begin
      read_data2 = '0;
      if (rs2 != '0 && !reset) begin
         if (write_live && rd == rs2) begin
            read_data2 = write_data;
         end else begin
            read_data2 = regs[rs2];
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a table of {inputs, expected reads}
// records plus a reset sweep; expectations go through a scoreboard queue.
module tb_register_file;

   localparam int N    = 64;
   localparam int ADDR = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            reg_write;
   logic [ADDR-1:0] rd;
   logic [N-1:0]    write_data;
   logic [ADDR-1:0] rs1;
   logic [ADDR-1:0] rs2;
   logic [N-1:0]    read_data1;
   logic [N-1:0]    read_data2;

   int checks   = 0;
   int failures = 0;

   register_file #(.N(N), .ADDR(ADDR)) dut (
      .clk        (clk),
      .reset      (reset),
      .reg_write  (reg_write),
      .rd         (rd),
      .write_data (write_data),
      .rs1        (rs1),
      .rs2        (rs2),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            rst;
      logic            we;
      logic [ADDR-1:0] rd;
      logic [N-1:0]    wd;
      logic [ADDR-1:0] rs1;
      logic [ADDR-1:0] rs2;
      logic [N-1:0]    e1;
      logic [N-1:0]    e2;
      bit              tick;
      string           name;
   } vec_t;

   typedef struct {
      logic [N-1:0] e1;
      logic [N-1:0] e2;
      string        name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic add(input logic rst_i, input logic we_i, input int rd_i,
                      input logic [N-1:0] wd_i, input int rs1_i, input int rs2_i,
                      input logic [N-1:0] e1_i, input logic [N-1:0] e2_i,
                      input bit tick_i, input string name_i);
      vec_t v;
      v.rst  = rst_i;
      v.we   = we_i;
      v.rd   = ADDR'(rd_i);
      v.wd   = wd_i;
      v.rs1  = ADDR'(rs1_i);
      v.rs2  = ADDR'(rs2_i);
      v.e1   = e1_i;
      v.e2   = e2_i;
      v.tick = tick_i;
      v.name = name_i;
      vecs.push_back(v);
   endtask

   // Drive inputs and queue the expected read values
   task automatic drive(input logic rst_i, input logic we_i, input logic [ADDR-1:0] rd_i,
                        input logic [N-1:0] wd_i, input logic [ADDR-1:0] rs1_i,
                        input logic [ADDR-1:0] rs2_i, input logic [N-1:0] e1_i,
                        input logic [N-1:0] e2_i, input string name_i);
      exp_t e;
      reset      = rst_i;
      reg_write  = we_i;
      rd         = rd_i;
      write_data = wd_i;
      rs1        = rs1_i;
      rs2        = rs2_i;
      e.e1   = e1_i;
      e.e2   = e2_i;
      e.name = name_i;
      sb.push_back(e);
   endtask

   // Let the combinational reads settle, then pop and compare both ports
   task automatic check_reads();
      exp_t e;
      #1;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty: got no expectation, required one");
      end else begin
         e = sb.pop_front();
         if (read_data1 !== e.e1) begin
            failures++;
            $display("FAIL %s port1: got %h required %h", e.name, read_data1, e.e1);
         end
         checks++;
         if (read_data2 !== e.e2) begin
            failures++;
            $display("FAIL %s port2: got %h required %h", e.name, read_data2, e.e2);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [N-1:0] PAT5  = 64'h0123_4567_89AB_CDEF;
   localparam logic [N-1:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      // T2: full-width writes, bypass on the second write, x6 untouched
      add(0, 1, 5,  PAT5,     5, 6,  PAT5,     0,     1, "t2_wr_x5");
      add(0, 1, 31, ONES,     5, 31, PAT5,     ONES,  1, "t2_wr_x31_bypass");
      add(0, 0, 0,  0,        5, 31, PAT5,     ONES,  0, "t2_read_back");
      add(0, 0, 0,  0,        6, 6,  0,        0,     0, "t2_x6_zero");
      // T3: x0 writes are dropped and never bypassed
      add(0, 1, 0,  64'hDEAD, 0, 5,  0,        PAT5,  1, "t3_x0_no_bypass");
      add(0, 0, 0,  0,        0, 31, 0,        ONES,  0, "t3_x0_after_edge");
      // T4: bypass onto both ports, then stored value after the edge
      add(0, 1, 7,  64'h11,   7, 0,  64'h11,   0,     1, "t4_wr_x7_11");
      add(0, 0, 0,  0,        7, 7,  64'h11,   64'h11,0, "t4_x7_holds_11");
      add(0, 1, 7,  64'h22,   7, 7,  64'h22,   64'h22,1, "t4_bypass_both");
      add(0, 0, 7,  64'h22,   7, 7,  64'h22,   64'h22,0, "t4_after_edge");
      add(0, 1, 7,  64'h33,   5, 7,  PAT5,     64'h33,0, "t4_other_reg_old");
      add(0, 0, 7,  64'h33,   7, 5,  64'h22,   PAT5,  0, "t4_no_edge_no_store");
      // T5: disabled writes hold; writing x9 leaves neighbours alone
      add(0, 0, 9,  64'hAA,   9, 9,  0,        0,     1, "t5_hold_1");
      add(0, 0, 9,  64'hAA,   9, 9,  0,        0,     1, "t5_hold_2");
      add(0, 0, 9,  64'hAA,   9, 9,  0,        0,     1, "t5_hold_3");
      add(0, 0, 0,  0,        9, 8,  0,        0,     0, "t5_x9_unchanged");
      add(0, 1, 9,  64'h99,   8, 10, 0,        0,     1, "t5_wr_x9");
      add(0, 0, 0,  0,        9, 8,  64'h99,   0,     0, "t5_x9_x8");
      add(0, 0, 0,  0,        10, 9, 0,        64'h99,0, "t5_x10_x9");
      // T6: reset in the middle of a write sequence clears everything
      add(0, 1, 3,  64'h33,   3, 0,  64'h33,   0,     1, "t6_wr_x3");
      add(0, 1, 4,  64'h44,   3, 4,  64'h33,   64'h44,1, "t6_wr_x4");
      add(1, 1, 3,  64'h99,   3, 4,  0,        0,     1, "t6_reset_with_write");
      add(0, 0, 0,  0,        3, 4,  0,        0,     0, "t6_x3_x4_cleared");
      add(0, 0, 0,  0,        5, 9,  0,        0,     0, "t6_x5_x9_cleared");
      add(0, 0, 0,  0,        31, 7, 0,        0,     0, "t6_x31_x7_cleared");

      // Initial reset edge
      reset = 1'b1; reg_write = 1'b0; rd = '0; write_data = '0; rs1 = '0; rs2 = '0;
      tick();

      // T1: reads forced to zero while reset is held, even with a write pending
      drive(1, 1, 5'd5, 64'hFF, 5'd5, 5'd5, 0, 0, "t1_reset_forces_zero");
      check_reads();
      tick();
      for (int i = 1; i < 32; i++) begin
         drive(0, 0, '0, '0, ADDR'(i), ADDR'(32 - i), 0, 0, $sformatf("t1_sweep_%0d", i));
         check_reads();
      end

      // Table of vectors
      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k].rst, vecs[k].we, vecs[k].rd, vecs[k].wd, vecs[k].rs1, vecs[k].rs2,
               vecs[k].e1, vecs[k].e2, vecs[k].name);
         check_reads();
         if (vecs[k].tick) tick();
      end

      // Hand sequence: back-to-back writes to one register, bypass then store
      drive(0, 1, 5'd12, 64'hA5A5, 5'd12, 5'd0, 64'hA5A5, 0, "seq_wr12_a");
      check_reads();
      tick();
      drive(0, 1, 5'd12, 64'h5A5A, 5'd12, 5'd12, 64'h5A5A, 64'h5A5A, "seq_wr12_b");
      check_reads();
      tick();
      drive(0, 0, 5'd12, 64'h0, 5'd12, 5'd0, 64'h5A5A, 0, "seq_x12_final");
      check_reads();

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
